// File: rtl/btb_pkg.sv
// Shared field layout and helpers for the 2-way BTB set format.
package btb_pkg;

    localparam int unsigned WAY_W   = 62;
    localparam int unsigned VALID_B = 61;
    localparam int unsigned TAG_HI  = 60;
    localparam int unsigned TAG_LO  = 34;
    localparam int unsigned TGT_HI  = 33;
    localparam int unsigned TGT_LO  = 2;
    localparam int unsigned CTR_HI  = 1;
    localparam int unsigned CTR_LO  = 0;
    localparam int unsigned LRU_B   = 124;
    localparam int unsigned TAG_W   = 27;
    localparam int unsigned IDX_W   = 3;

    function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/btb_way_decode.sv
// Splits one BTB way into its fields and compares its tag.
module btb_way_decode
    import btb_pkg::*;
(
    input  logic [WAY_W-1:0] way,
    input  logic [TAG_W-1:0] tag,
    output logic             valid,
    output logic             hit,
    output logic [31:0]      target,
    output logic [1:0]       ctr
);

    assign valid  = way[VALID_B];
    assign hit    = valid && (way[TAG_HI:TAG_LO] == tag);
    assign target = way[TGT_HI:TGT_LO];
    assign ctr    = way[CTR_HI:CTR_LO];

endmodule

// File: rtl/btb_controller.sv
// BTB lookup/prediction and 2-stage read-modify-write update engine with stats counters.
module btb_controller
    import btb_pkg::*;
#(
    parameter int unsigned STAT_W   = 32,
    parameter logic [1:0]  INIT_CTR = 2'b10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       if_pc,
    output logic [IDX_W-1:0]  read_index,
    input  logic [127:0]      read_set,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              ex_upd_valid,
    input  logic [31:0]       ex_upd_pc,
    input  logic              ex_upd_taken,
    input  logic [31:0]       ex_upd_target,
    output logic [IDX_W-1:0]  update_index,
    input  logic [127:0]      update_set,
    output logic [IDX_W-1:0]  write_index,
    output logic [127:0]      write_set,
    output logic              write_en,
    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_allocs
);

    logic        lk0_valid, lk0_hit, lk1_valid, lk1_hit;
    logic [31:0] lk0_target, lk1_target;
    logic [1:0]  lk0_ctr, lk1_ctr;

    assign read_index = if_pc[4:2];

    btb_way_decode u_lk_way0 (
        .way    (read_set[WAY_W-1:0]),
        .tag    (if_pc[31:5]),
        .valid  (lk0_valid),
        .hit    (lk0_hit),
        .target (lk0_target),
        .ctr    (lk0_ctr)
    );

    btb_way_decode u_lk_way1 (
        .way    (read_set[2*WAY_W-1:WAY_W]),
        .tag    (if_pc[31:5]),
        .valid  (lk1_valid),
        .hit    (lk1_hit),
        .target (lk1_target),
        .ctr    (lk1_ctr)
    );

    // Way0 wins when both ways match.
    always_comb begin
        pred_hit    = lk0_hit || lk1_hit;
        pred_taken  = 1'b0;
        pred_target = '0;
        if (lk0_hit) begin
            pred_taken  = lk0_ctr[1];
            pred_target = lk0_target;
        end else if (lk1_hit) begin
            pred_taken  = lk1_ctr[1];
            pred_target = lk1_target;
        end
    end

    logic        s1_valid, s1_taken;
    logic [31:0] s1_pc, s1_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_pc     <= '0;
            s1_taken  <= 1'b0;
            s1_target <= '0;
        end else begin
            s1_valid <= ex_upd_valid;
            if (ex_upd_valid) begin
                s1_pc     <= ex_upd_pc;
                s1_taken  <= ex_upd_taken;
                s1_target <= ex_upd_target;
            end
        end
    end

    logic        up0_valid, up0_hit, up1_valid, up1_hit;
    logic [31:0] up0_target, up1_target;
    logic [1:0]  up0_ctr, up1_ctr;

    assign update_index = s1_pc[4:2];
    assign write_index  = update_index;

    btb_way_decode u_up_way0 (
        .way    (update_set[WAY_W-1:0]),
        .tag    (s1_pc[31:5]),
        .valid  (up0_valid),
        .hit    (up0_hit),
        .target (up0_target),
        .ctr    (up0_ctr)
    );

    btb_way_decode u_up_way1 (
        .way    (update_set[2*WAY_W-1:WAY_W]),
        .tag    (s1_pc[31:5]),
        .valid  (up1_valid),
        .hit    (up1_hit),
        .target (up1_target),
        .ctr    (up1_ctr)
    );

    logic             alloc, sel_way;
    logic [WAY_W-1:0] new_way;

    always_comb begin
        write_set = {3'b000, update_set[LRU_B:0]};
        write_en  = 1'b0;
        alloc     = 1'b0;
        sel_way   = 1'b0;
        new_way   = '0;
        if (s1_valid && (up0_hit || up1_hit)) begin
            sel_way  = !up0_hit;
            new_way  = sel_way ? update_set[2*WAY_W-1:WAY_W] : update_set[WAY_W-1:0];
            new_way[CTR_HI:CTR_LO] = sat_ctr(sel_way ? up1_ctr : up0_ctr, s1_taken);
            if (s1_taken) begin
                new_way[TGT_HI:TGT_LO] = s1_target;
            end
            write_en = 1'b1;
        end else if (s1_valid && s1_taken) begin
            // Fill an empty way first, otherwise evict the LRU way.
            if (!up0_valid) begin
                sel_way = 1'b0;
            end else if (!up1_valid) begin
                sel_way = 1'b1;
            end else begin
                sel_way = update_set[LRU_B];
            end
            new_way  = {1'b1, s1_pc[31:5], s1_target, INIT_CTR};
            write_en = 1'b1;
            alloc    = 1'b1;
        end
        if (write_en) begin
            if (sel_way) begin
                write_set[2*WAY_W-1:WAY_W] = new_way;
            end else begin
                write_set[WAY_W-1:0] = new_way;
            end
            write_set[LRU_B] = !sel_way;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
            stat_allocs  <= '0;
        end else begin
            if (if_valid) begin
                stat_lookups <= stat_lookups + STAT_W'(1);
            end
            if (if_valid && pred_hit) begin
                stat_hits <= stat_hits + STAT_W'(1);
            end
            if (alloc) begin
                stat_allocs <= stat_allocs + STAT_W'(1);
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{if_pc[1:0], read_set[127:124], lk0_valid, lk1_valid, s1_pc[1:0],
                           update_set[127:125], up0_target, up1_target};

endmodule

// File: tb/tb_btb_controller.sv
// Directed bench for btb_controller with a forwarding storage-file model and write scoreboard.
module tb_btb_controller;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         if_valid = 1'b0;
    logic [31:0]  if_pc = '0;
    logic [2:0]   read_index;
    logic [127:0] read_set;
    logic         pred_hit, pred_taken;
    logic [31:0]  pred_target;
    logic         ex_upd_valid = 1'b0;
    logic [31:0]  ex_upd_pc = '0;
    logic         ex_upd_taken = 1'b0;
    logic [31:0]  ex_upd_target = '0;
    logic [2:0]   update_index, write_index;
    logic [127:0] update_set, write_set;
    logic         write_en;
    logic [31:0]  stat_lookups, stat_hits, stat_allocs;

    always #5 clk = ~clk;

    btb_controller dut (
        .clk           (clk),
        .rst           (rst),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .read_index    (read_index),
        .read_set      (read_set),
        .pred_hit      (pred_hit),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .ex_upd_valid  (ex_upd_valid),
        .ex_upd_pc     (ex_upd_pc),
        .ex_upd_taken  (ex_upd_taken),
        .ex_upd_target (ex_upd_target),
        .update_index  (update_index),
        .update_set    (update_set),
        .write_index   (write_index),
        .write_set     (write_set),
        .write_en      (write_en),
        .stat_lookups  (stat_lookups),
        .stat_hits     (stat_hits),
        .stat_allocs   (stat_allocs)
    );

    // Storage file: write-forwarded lookup port, plain update read port.
    logic [127:0] mem [8] = '{default: '0};
    always @(posedge clk) if (write_en) mem[write_index] <= write_set;
    assign read_set   = (write_en && write_index == read_index) ? write_set : mem[read_index];
    assign update_set = mem[update_index];

    typedef struct packed {
        logic         en;
        logic [2:0]   idx;
        logic [127:0] set;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic        pend = 1'b0;
    logic        lk_pend = 1'b0;
    logic        lk_hit, lk_taken;
    logic [31:0] lk_tgt;
    logic [2:0]  lk_idx;

    function automatic logic [61:0] way(input logic [31:0] pc, input logic [31:0] tgt,
                                        input logic [1:0] ctr);
        return {1'b1, pc[31:5], tgt, ctr};
    endfunction

    function automatic logic [127:0] mkset(input logic lru, input logic [61:0] w1,
                                           input logic [61:0] w0);
        return {3'b000, lru, w1, w0};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                             input logic en, input logic [127:0] set);
        exp_t e;
        ex_upd_valid  = 1'b1;
        ex_upd_pc     = pc;
        ex_upd_taken  = taken;
        ex_upd_target = tgt;
        e.en  = en;
        e.idx = pc[4:2];
        e.set = set;
        exp_q.push_back(e);
    endtask

    task automatic drive_lk(input logic [31:0] pc, input logic hit, input logic taken,
                            input logic [31:0] tgt);
        if_valid = 1'b1;
        if_pc    = pc;
        lk_pend  = 1'b1;
        lk_hit   = hit;
        lk_taken = taken;
        lk_tgt   = tgt;
        lk_idx   = pc[4:2];
    endtask

    // Called at a falling edge with this cycle's inputs already driven.
    task automatic step();
        exp_t e;
        #1;
        if (pend && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("write_en", 128'(write_en), 128'(e.en));
            if (e.en) begin
                chk("update_index", 128'(update_index), 128'(e.idx));
                chk("write_index", 128'(write_index), 128'(e.idx));
                chk("write_set", write_set, e.set);
            end
        end else begin
            chk("write_en_idle", 128'(write_en), 128'(1'b0));
        end
        if (lk_pend) begin
            chk("read_index", 128'(read_index), 128'(lk_idx));
            chk("pred_hit", 128'(pred_hit), 128'(lk_hit));
            chk("pred_taken", 128'(pred_taken), 128'(lk_taken));
            chk("pred_target", 128'(pred_target), 128'(lk_tgt));
        end
        @(posedge clk);
        #1;
        pend         = ex_upd_valid;
        ex_upd_valid = 1'b0;
        if_valid     = 1'b0;
        lk_pend      = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_stats(input string tag, input int lk, input int ht, input int al);
        chk({tag, "_lookups"}, 128'(stat_lookups), 128'(lk));
        chk({tag, "_hits"}, 128'(stat_hits), 128'(ht));
        chk({tag, "_allocs"}, 128'(stat_allocs), 128'(al));
    endtask

    logic [61:0] w1004_00, w1004_01, w1004_10, w1004_11, w2004, w3004;

    initial begin
        w1004_00 = way(32'h1004, 32'h2000, 2'b00);
        w1004_01 = way(32'h1004, 32'h2000, 2'b01);
        w1004_10 = way(32'h1004, 32'h2000, 2'b10);
        w1004_11 = way(32'h1004, 32'h2000, 2'b11);
        w2004    = way(32'h2004, 32'h3000, 2'b10);
        w3004    = way(32'h3004, 32'h4000, 2'b10);

        repeat (2) @(negedge clk);
        #1;
        chk("reset_write_en", 128'(write_en), 128'(1'b0));
        chk_stats("reset", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Lookup on an empty file.
        drive_lk(32'h1004, 1'b0, 1'b0, 32'h0);
        step();
        chk_stats("empty", 1, 0, 0);

        // Allocate into way0; lookup during the write sees forwarded data.
        drive_upd(32'h1004, 1'b1, 32'h2000, 1'b1, mkset(1'b1, 62'h0, w1004_10));
        step();
        drive_lk(32'h1004, 1'b1, 1'b1, 32'h2000);
        step();
        chk_stats("alloc1", 2, 1, 1);

        // Not-taken updates saturate the counter at 0.
        drive_upd(32'h1004, 1'b0, 32'h0, 1'b1, mkset(1'b1, 62'h0, w1004_01));
        step();
        drive_upd(32'h1004, 1'b0, 32'h0, 1'b1, mkset(1'b1, 62'h0, w1004_00));
        step();
        step();
        drive_lk(32'h1004, 1'b1, 1'b0, 32'h2000);
        drive_upd(32'h1004, 1'b0, 32'h0, 1'b1, mkset(1'b1, 62'h0, w1004_00));
        step();
        step();

        // Fill way1, touch way0, then evict the LRU way1.
        drive_upd(32'h2004, 1'b1, 32'h3000, 1'b1, mkset(1'b0, w2004, w1004_00));
        step();
        drive_upd(32'h1004, 1'b1, 32'h2000, 1'b1, mkset(1'b1, w2004, w1004_01));
        step();
        drive_upd(32'h3004, 1'b1, 32'h4000, 1'b1, mkset(1'b0, w3004, w1004_01));
        step();
        step();
        chk_stats("evict", 3, 2, 3);
        drive_lk(32'h2004, 1'b0, 1'b0, 32'h0);
        step();
        drive_lk(32'h3004, 1'b1, 1'b1, 32'h4000);
        step();

        // Back-to-back taken updates to the same set.
        drive_upd(32'h1004, 1'b1, 32'h2000, 1'b1, mkset(1'b1, w3004, w1004_10));
        step();
        drive_upd(32'h1004, 1'b1, 32'h2000, 1'b1, mkset(1'b1, w3004, w1004_11));
        step();
        step();

        // Miss and not taken writes nothing; miss and taken allocates at index 2.
        drive_upd(32'h5008, 1'b0, 32'h0, 1'b0, '0);
        step();
        drive_upd(32'h5008, 1'b1, 32'h0abc, 1'b1,
                  mkset(1'b1, 62'h0, way(32'h5008, 32'h0abc, 2'b10)));
        step();
        step();
        drive_lk(32'h5008, 1'b1, 1'b1, 32'h0abc);
        step();
        chk_stats("idx2", 6, 4, 4);

        // Reset while an update sits in stage 1.
        ex_upd_valid  = 1'b1;
        ex_upd_pc     = 32'h5008;
        ex_upd_taken  = 1'b0;
        ex_upd_target = 32'h0;
        @(posedge clk);
        #1;
        ex_upd_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("pre_rst_write_en", 128'(write_en), 128'(1'b1));
        rst = 1'b1;
        #1;
        chk("rst_write_en", 128'(write_en), 128'(1'b0));
        chk_stats("rst", 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_no_write", mem[2], mkset(1'b1, 62'h0, way(32'h5008, 32'h0abc, 2'b10)));
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
